// File: rtl/burst_types.sv
// Shared types and widths for the physical-memory burst adapter.
package burst_types;
    localparam int LINE_WIDTH_DEF = 256;
    localparam int BEAT_WIDTH_DEF = 64;
    localparam int OFFSET_BITS    = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } burst_state_t;
endpackage

// File: rtl/pmem_burst_adapter_beat_line_buffer.sv
// Line-wide register with full-line load and per-beat write/read by index.
module beat_line_buffer #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int NUM_BEATS  = LINE_WIDTH / BEAT_WIDTH,
    parameter int IDX_W      = $clog2(NUM_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [LINE_WIDTH-1:0] load_line_i,
    input  logic                  beat_we_i,
    input  logic [IDX_W-1:0]      beat_idx_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    output logic [BEAT_WIDTH-1:0] beat_o,
    output logic [LINE_WIDTH-1:0] line_next_o
);
    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_line_i;
        end else if (beat_we_i) begin
            line_d[beat_idx_i*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign beat_o      = line_q[beat_idx_i*BEAT_WIDTH +: BEAT_WIDTH];
    // Includes the beat arriving this cycle, so the last beat can be
    // published to pmem_rdata without an extra cycle.
    assign line_next_o = line_d;
endmodule

// File: rtl/pmem_burst_adapter.sv
// Splits 256-bit line reads/writes into 4x64-bit bursts and reassembles
// read beats into a registered line with a single-cycle pmem_resp.
module pmem_burst_adapter
    import burst_types::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [31:0]           pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_resp,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [31:0]           bmem_address,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_resp,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata
);
    localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int IDX_W     = $clog2(NUM_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    burst_state_t          state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    logic                  load;
    logic                  beat_we;
    logic [LINE_WIDTH-1:0] line_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        beat_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    addr_d  = {pmem_address[31:OFFSET_BITS], OFFSET_BITS'(0)};
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (pmem_read) begin
                    addr_d  = {pmem_address[31:OFFSET_BITS], OFFSET_BITS'(0)};
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                beat_we = bmem_resp;
                if (bmem_resp) begin
                    if (cnt_q == LAST_IDX) begin
                        rdata_d = line_next;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (bmem_resp) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    beat_line_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .NUM_BEATS  (NUM_BEATS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_line_i (pmem_wdata),
        .beat_we_i   (beat_we),
        .beat_idx_i  (cnt_q),
        .beat_data_i (bmem_rdata),
        .beat_o      (bmem_wdata),
        .line_next_o (line_next)
    );

    assign pmem_resp    = (state_q == DONE);
    assign pmem_rdata   = rdata_q;
    assign bmem_read    = (state_q == RD_BURST);
    assign bmem_write   = (state_q == WR_BURST);
    assign bmem_address = addr_q;
endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed bench with a beat-level memory model and line/beat scoreboards.
module tb_pmem_burst_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         bmem_read, bmem_write;
    logic [31:0]  bmem_address;
    logic [63:0]  bmem_wdata;
    logic         bmem_resp;
    logic [63:0]  bmem_rdata;

    int total = 0;
    int bad   = 0;

    logic [63:0]  mem [logic [31:0]];
    logic [255:0] rq [$];
    logic [63:0]  wq [$];
    logic [255:0] last_rd;

    always #5 clk = ~clk;

    pmem_burst_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_address (bmem_address),
        .bmem_wdata   (bmem_wdata),
        .bmem_resp    (bmem_resp),
        .bmem_rdata   (bmem_rdata)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic logic [255:0] mline(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 4; i++) l[i*64 +: 64] = mrd(b + 32'(i*8));
        return l;
    endfunction

    task automatic xact(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [255:0] wl,
                        input int stall_beat, input int stall_n,
                        input int rst_beat, output int cyc);
        logic [31:0]  base;
        logic [255:0] exp_line;
        int beat;
        int st;
        bit done;
        base = {addr[31:5], 5'b0};
        beat = 0;
        st   = 0;
        done = 1'b0;
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wl;
        if (wr) begin
            for (int i = 0; i < 4; i++) wq.push_back(wl[i*64 +: 64]);
        end else begin
            rq.push_back(mline(base));
        end
        cyc = 1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            cyc++;
            // Upstream fields change mid-burst; the latched copies must win.
            pmem_address = ~addr;
            pmem_wdata   = ~wl;
            if (pmem_resp) begin
                done       = 1'b1;
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                bmem_resp  = 1'b0;
                if (wr) begin
                    chk("rdata_kept_on_write", pmem_rdata, last_rd);
                end else begin
                    exp_line = rq.pop_front();
                    chk("rd_line", pmem_rdata, exp_line);
                    last_rd = exp_line;
                end
                @(negedge clk);
                chk("resp_one_cycle", pmem_resp, 1'b0);
                chk("idle_no_bread", bmem_read, 1'b0);
            end else begin
                chk("bmem_read", bmem_read, !wr && rd);
                chk("bmem_write", bmem_write, wr);
                chk("bmem_addr", bmem_address, base);
                if (wr && wq.size() > 0) chk("wbeat", bmem_wdata, wq[0]);
                if (rst_beat >= 0 && beat == rst_beat) begin
                    rst       = 1'b1;
                    bmem_resp = 1'b0;
                    @(negedge clk);
                    chk("rst_bread", bmem_read, 1'b0);
                    chk("rst_bwrite", bmem_write, 1'b0);
                    chk("rst_resp", pmem_resp, 1'b0);
                    chk("rst_rdata", pmem_rdata, 256'h0);
                    rst       = 1'b0;
                    pmem_read = 1'b0;
                    pmem_write = 1'b0;
                    void'(rq.pop_front());
                    last_rd = '0;
                    done    = 1'b1;
                end else if (beat == stall_beat && st < stall_n) begin
                    bmem_resp = 1'b0;
                    st++;
                end else begin
                    bmem_resp = 1'b1;
                    if (wr) begin
                        mem[base + 32'(beat*8)] = wq.pop_front();
                    end else begin
                        bmem_rdata = mrd(base + 32'(beat*8));
                    end
                    beat++;
                end
            end
        end
        if (!done) chk("timeout", 1'b0, 1'b1);
    endtask

    int cyc;
    logic [255:0] wl;

    initial begin
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        bmem_resp = 1'b0;
        bmem_rdata = '0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        chk("rst_pmem_resp", pmem_resp, 1'b0);
        chk("rst_bmem_rw", {bmem_read, bmem_write}, 2'b00);
        chk("rst_bmem_addr", bmem_address, 32'h0);
        chk("rst_bmem_wdata", bmem_wdata, 64'h0);
        chk("rst_pmem_rdata", pmem_rdata, 256'h0);
        rst = 1'b0;

        // 1: zero-wait read, unaligned address
        mem[32'h60] = {16{4'h1}};
        mem[32'h68] = {16{4'h2}};
        mem[32'h70] = {16{4'h3}};
        mem[32'h78] = {16{4'h4}};
        xact(1'b1, 1'b0, 32'h64, '0, -1, 0, -1, cyc);
        chk("t1_latency", cyc, 6);
        chk("t1_line", pmem_rdata,
            {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        // 2: write with two stall cycles before beat 1
        wl = {64'hD3D3_0000_3333_D3D3, 64'hD2D2_0000_2222_D2D2,
              64'hD1D1_0000_1111_D1D1, 64'hD0D0_0000_0000_D0D0};
        xact(1'b0, 1'b1, 32'h1000, wl, 1, 2, -1, cyc);
        chk("t2_latency", cyc, 8);
        chk("t2_mem_d1", mem[32'h1008], 64'hD1D1_0000_1111_D1D1);
        chk("t2_mem_d3", mem[32'h1018], 64'hD3D3_0000_3333_D3D3);

        // 3: back-to-back write then read of the same line
        wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom};
        xact(1'b0, 1'b1, 32'h80, wl, -1, 0, -1, cyc);
        xact(1'b1, 1'b0, 32'h80, '0, 2, 1, -1, cyc);
        chk("t3_readback", pmem_rdata, wl);
        chk("t3_latency", cyc, 7);

        // 4: simultaneous read and write, write wins
        wl = {4{64'hCAFE_F00D_1234_5678}};
        xact(1'b1, 1'b1, 32'h2000, wl, -1, 0, -1, cyc);
        chk("t4_mem", mem[32'h2010], 64'hCAFE_F00D_1234_5678);

        // 5: reset after two beats of a read, then a clean read
        for (int i = 0; i < 4; i++) mem[32'h200 + 32'(i*8)] = 64'(i + 100);
        xact(1'b1, 1'b0, 32'h200, '0, -1, 0, 2, cyc);
        xact(1'b1, 1'b0, 32'h200, '0, -1, 0, -1, cyc);
        chk("t5_line", pmem_rdata, {64'd103, 64'd102, 64'd101, 64'd100});

        // 6: spurious bmem_resp while idle
        @(negedge clk);
        bmem_resp = 1'b1;
        bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_resp", pmem_resp, 1'b0);
            chk("t6_bmem_rw", {bmem_read, bmem_write}, 2'b00);
            chk("t6_rdata", pmem_rdata, last_rd);
        end
        bmem_resp = 1'b0;
        xact(1'b1, 1'b0, 32'h7C, '0, -1, 0, -1, cyc);
        chk("t6_after_latency", cyc, 6);
        chk("t6_after_line", pmem_rdata,
            {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        chk("sb_empty", rq.size() + wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
